reg_trace_monitor: RTL and testbench

//  Parametrised register-file change tracer fed by the core's flat reg_dump bus.
//  - Compares each watched register against a per-register shadow of its last

---
 rtl/reg_trace_monitor_pkg.sv | 19 +
 rtl/reg_trace_monitor_if.sv | 28 ++
 rtl/reg_trace_monitor_fifo.sv | 52 +++++
 rtl/reg_trace_monitor.sv | 141 ++++++++++++++
 tb/tb_reg_trace_monitor.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/reg_trace_monitor_pkg.sv
// Shared constants and helpers for the register-change tracer.
// Event layout, MSB first: {idx, old, new, cycle}.
package reg_trace_monitor_pkg;

  localparam int DEF_XLEN       = 32;
  localparam int DEF_NREGS      = 32;
  localparam int DEF_FIFO_DEPTH = 8;
  localparam int DEF_TS_W       = 32;
  localparam int DEF_IDLE_LIMIT = 64;

  localparam int               STALL_W   = 16;
  localparam logic [STALL_W-1:0] STALL_MAX = '1;

  // Width of one packed event record.
  function automatic int evt_width(input int idx_w, input int xlen, input int ts_w);
    return idx_w + 2 * xlen + ts_w;
  endfunction

endpackage

// File: rtl/reg_trace_monitor_if.sv
// Event stream from the tracer to its consumer.
// Valid/ready: a beat transfers on a rising edge where evt_valid & evt_ready are both 1;
// while evt_valid is 1 and evt_ready is 0, every payload field is held stable.
interface reg_trace_monitor_if #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int TS_W  = 32
);
  localparam int IDX_W = $clog2(NREGS);

  logic             evt_valid;
  logic             evt_ready;
  logic [IDX_W-1:0] evt_idx;
  logic [XLEN-1:0]  evt_old;
  logic [XLEN-1:0]  evt_new;
  logic [TS_W-1:0]  evt_cycle;

  modport master (
    output evt_valid, evt_idx, evt_old, evt_new, evt_cycle,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_idx, evt_old, evt_new, evt_cycle,
    output evt_ready
  );

endinterface

// File: rtl/reg_trace_monitor_fifo.sv
// First-word-fall-through synchronous FIFO holding trace events.
// The head reads as zero while empty so idle outputs stay quiet.
module reg_trace_monitor_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Extra pointer bit distinguishes full from empty when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= push_data;
  end

  assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/reg_trace_monitor.sv
// Register-file change tracer: shadows each watched register, emits one
// {idx, old, new, cycle} event per change and flags quiescence.
module reg_trace_monitor
  import reg_trace_monitor_pkg::*;
#(
  parameter int XLEN       = DEF_XLEN,
  parameter int NREGS      = DEF_NREGS,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int TS_W       = DEF_TS_W,
  parameter int IDLE_LIMIT = DEF_IDLE_LIMIT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic [NREGS*XLEN-1:0] reg_dump,
  input  logic [NREGS-1:0]      watch_mask,
  reg_trace_monitor_if.master   evt,
  output logic [STALL_W-1:0]    stall_cnt,
  output logic                  idle
);

  localparam int IDX_W  = $clog2(NREGS);
  localparam int IDLE_W = $clog2(IDLE_LIMIT + 1);
  localparam int EVT_W  = evt_width(IDX_W, XLEN, TS_W);

  logic [XLEN-1:0]       cur     [NREGS];
  logic [XLEN-1:0]       shadow  [NREGS];
  logic [NREGS-1:0]      pending;
  logic                  any_pending;
  logic [IDX_W-1:0]      rr_ptr;
  logic [IDX_W-1:0]      sel_idx;
  logic [IDX_W-1:0]      cand;
  logic [TS_W-1:0]       cyc;
  logic [NREGS*XLEN-1:0] prev_dump;
  logic [IDLE_W-1:0]     idle_cnt;

  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  pop;
  logic                  push;
  logic [EVT_W-1:0]      push_data;
  logic [EVT_W-1:0]      head;

  always_comb begin
    for (int r = 0; r < NREGS; r++) begin
      cur[r]     = reg_dump[XLEN*r +: XLEN];
      pending[r] = watch_mask[r] & (cur[r] != shadow[r]);
    end
  end

  assign any_pending = |pending;

  // Scan downward so the last hit is the nearest pending index at or after rr_ptr.
  always_comb begin
    sel_idx = rr_ptr;
    cand    = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      cand = rr_ptr + IDX_W'(i);
      if (pending[cand]) sel_idx = cand;
    end
  end

  assign pop       = ~fifo_empty & evt.evt_ready;
  assign push      = en & ~clr & any_pending & (~fifo_full | pop);
  assign push_data = {sel_idx, shadow[sel_idx], cur[sel_idx], cyc};

  reg_trace_monitor_fifo #(
    .WIDTH (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (clr),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign evt.evt_valid = ~fifo_empty;
  assign evt.evt_idx   = head[EVT_W-1 -: IDX_W];
  assign evt.evt_old   = head[EVT_W-IDX_W-1 -: XLEN];
  assign evt.evt_new   = head[TS_W+XLEN-1 -: XLEN];
  assign evt.evt_cycle = head[TS_W-1:0];

  // Shadow holds the last value reported per register; clr re-baselines all of them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < NREGS; r++) shadow[r] <= '0;
    end else if (clr) begin
      for (int r = 0; r < NREGS; r++) shadow[r] <= cur[r];
    end else if (push) begin
      shadow[sel_idx] <= cur[sel_idx];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
    end else if (clr) begin
      rr_ptr <= '0;
    end else if (push) begin
      rr_ptr <= sel_idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cyc <= '0;
    else      cyc <= cyc + 1'b1;
  end

  // Counts back-pressure cycles where a change is waiting on a full FIFO.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (!clr && en && any_pending && fifo_full && !pop && stall_cnt != STALL_MAX) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_dump <= '0;
    else      prev_dump <= reg_dump;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idle_cnt <= '0;
    end else if (clr || any_pending || reg_dump != prev_dump) begin
      idle_cnt <= '0;
    end else if (idle_cnt != IDLE_W'(IDLE_LIMIT)) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  assign idle = (idle_cnt == IDLE_W'(IDLE_LIMIT));

endmodule

// File: tb/tb_reg_trace_monitor.sv
// Directed bench for reg_trace_monitor: latency, ordering, back-pressure,
// coalescing, clr, masking, enable, quiescence and mid-run reset.
module tb_reg_trace_monitor;

  localparam int XLEN       = 32;
  localparam int NREGS      = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int TS_W       = 16;
  localparam int IDLE_LIMIT = 8;
  localparam int IDX_W      = 4;
  localparam int EW         = IDX_W + 2 * XLEN + TS_W;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                  en;
  logic                  clr;
  logic [NREGS*XLEN-1:0] reg_dump;
  logic [NREGS-1:0]      watch_mask;
  logic [15:0]           stall_cnt;
  logic                  idle;

  reg_trace_monitor_if #(.XLEN(XLEN), .NREGS(NREGS), .TS_W(TS_W)) evt_if ();

  reg_trace_monitor #(
    .XLEN       (XLEN),
    .NREGS      (NREGS),
    .FIFO_DEPTH (FIFO_DEPTH),
    .TS_W       (TS_W),
    .IDLE_LIMIT (IDLE_LIMIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .clr        (clr),
    .reg_dump   (reg_dump),
    .watch_mask (watch_mask),
    .evt        (evt_if),
    .stall_cnt  (stall_cnt),
    .idle       (idle)
  );

  // Reference cycle counter: free-running from reset release.
  logic [TS_W-1:0] tb_cyc;
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cyc <= '0;
    else      tb_cyc <= tb_cyc + 1'b1;
  end

  // Scoreboard
  logic [EW-1:0] exp_q[$];
  int checks    = 0;
  int errors    = 0;
  int last_wait = 0;
  logic [TS_W-1:0] c0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver tasks
  task automatic set_reg(input int r, input logic [XLEN-1:0] v);
    reg_dump[XLEN*r +: XLEN] = v;
  endtask

  task automatic push_exp(input logic [IDX_W-1:0] idx, input logic [XLEN-1:0] o,
                          input logic [XLEN-1:0] n, input logic [TS_W-1:0] c);
    exp_q.push_back({idx, o, n, c});
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drain(input int n, input string tag);
    logic [EW-1:0] e;
    evt_if.evt_ready = 1'b1;
    for (int k = 0; k < n; k++) begin
      int w = 0;
      while (!evt_if.evt_valid && w < 20) begin
        @(negedge clk);
        w++;
      end
      last_wait = w;
      check($sformatf("%s_valid%0d", tag, k), evt_if.evt_valid, 1);
      e = exp_q.pop_front();
      check($sformatf("%s_idx%0d", tag, k), evt_if.evt_idx,   e[EW-1 -: IDX_W]);
      check($sformatf("%s_old%0d", tag, k), evt_if.evt_old,   e[EW-IDX_W-1 -: XLEN]);
      check($sformatf("%s_new%0d", tag, k), evt_if.evt_new,   e[TS_W+XLEN-1 -: XLEN]);
      check($sformatf("%s_cyc%0d", tag, k), evt_if.evt_cycle, e[TS_W-1:0]);
      @(negedge clk);
    end
    evt_if.evt_ready = 1'b0;
  endtask

  initial begin
    en               = 1'b1;
    clr              = 1'b0;
    reg_dump         = '0;
    watch_mask       = '1;
    evt_if.evt_ready = 1'b0;
    step(2);
    check("rst_valid", evt_if.evt_valid, 0);
    check("rst_idx",   evt_if.evt_idx,   0);
    check("rst_cycle", evt_if.evt_cycle, 0);
    check("rst_stall", stall_cnt,        0);
    check("rst_idle",  idle,             0);
    rst = 1'b1;
    step(2);

    // Single change: event visible one cycle later, stamped with the change cycle.
    set_reg(5, 7);
    push_exp(5, 0, 7, tb_cyc);
    check("t1_not_yet", evt_if.evt_valid, 0);
    step(1);
    check("t1_latency", evt_if.evt_valid, 1);
    drain(1, "t1");
    check("t1_empty", evt_if.evt_valid, 0);

    // Two changes in one cycle: idx 1 then idx 2 on consecutive cycles.
    set_reg(1, 3);
    set_reg(2, 4);
    push_exp(1, 0, 3, tb_cyc);
    push_exp(2, 0, 4, tb_cyc + 16'd1);
    drain(2, "t2");
    check("t2_back_to_back", last_wait, 0);

    // FIFO_DEPTH + 2 changes with the consumer stalled.
    c0 = tb_cyc;
    for (int r = 8; r < 14; r++) set_reg(r, 32'(100 + r));
    for (int r = 8; r < 12; r++) push_exp(4'(r), 0, 32'(100 + r), c0 + 16'(r - 8));
    step(8);
    check("t3_stall4", stall_cnt, 4);
    check("t3_head_valid", evt_if.evt_valid, 1);
    check("t3_head_held", evt_if.evt_idx, 8);

    // Coalescing while full: x3 0->9->11 is one event, x4 0->6->0 is none.
    set_reg(3, 9);
    step(1);
    set_reg(3, 11);
    set_reg(4, 6);
    step(1);
    set_reg(4, 0);
    step(1);
    check("t4_stall7", stall_cnt, 7);
    c0 = tb_cyc;
    push_exp(12, 0, 112, c0);
    push_exp(13, 0, 113, c0 + 16'd1);
    push_exp(3, 0, 11, c0 + 16'd2);
    drain(7, "t34");
    check("t4_stall_kept", stall_cnt, 7);
    step(3);
    check("t4_no_x4_event", evt_if.evt_valid, 0);

    // clr flushes queued events and re-baselines the shadows.
    set_reg(14, 55);
    set_reg(15, 66);
    step(2);
    check("t5_prefill", evt_if.evt_valid, 1);
    set_reg(0, 1);
    clr = 1'b1;
    step(1);
    clr = 1'b0;
    check("t5_flushed", evt_if.evt_valid, 0);
    step(2);
    check("t5_rebaselined", evt_if.evt_valid, 0);
    check("t5_stall_kept", stall_cnt, 7);

    // Masked register is ignored until unmasked.
    watch_mask[7] = 1'b0;
    set_reg(7, 77);
    step(3);
    check("t5_masked", evt_if.evt_valid, 0);
    watch_mask[7] = 1'b1;
    push_exp(7, 0, 77, tb_cyc);
    drain(1, "t5_unmask");

    // en low holds the change pending until re-enabled.
    en = 1'b0;
    set_reg(6, 5);
    step(3);
    check("en_off", evt_if.evt_valid, 0);
    en = 1'b1;
    push_exp(6, 0, 5, tb_cyc);
    drain(1, "en_on");

    // Quiescence after exactly IDLE_LIMIT quiet cycles, dropping on any change.
    set_reg(9, 1);
    step(1);
    check("t6_idle_reset", idle, 0);
    step(7);
    check("t6_idle_edge", idle, 0);
    step(1);
    check("t6_idle_set", idle, 1);
    set_reg(10, 5);
    step(1);
    check("t6_idle_drop", idle, 0);

    // Mid-burst reset clears everything immediately.
    set_reg(11, 1);
    set_reg(12, 2);
    step(1);
    check("t6_burst", evt_if.evt_valid, 1);
    #1;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", evt_if.evt_valid, 0);
    check("t6_rst_idx",   evt_if.evt_idx,   0);
    check("t6_rst_stall", stall_cnt,        0);
    check("t6_rst_idle",  idle,             0);
    step(1);
    rst = 1'b1;
    step(1);
    // Shadows are zero again, so x0 = 1 is re-reported from a cleared cycle stamp.
    check("t6_post_valid", evt_if.evt_valid, 1);
    check("t6_post_idx",   evt_if.evt_idx,   0);
    check("t6_post_old",   evt_if.evt_old,   0);
    check("t6_post_new",   evt_if.evt_new,   1);
    check("t6_post_cycle", evt_if.evt_cycle, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
